// File: rtl/knns_pkg.sv
// Shared types and defaults for the kNN result reader.
package knns_pkg;

  localparam int unsigned K_DEF = 20;
  localparam int unsigned W_DEF = 32;

  localparam logic [W_DEF-1:0] EMPTY_SENTINEL = '1;

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    SEND,
    FIN
  } state_e;

endpackage

// File: rtl/knns_last_detect.sv
// Flags that no mask bit above the current index is set, i.e. the current beat is the final one.
module knns_last_detect #(
  parameter int unsigned K  = 20,
  parameter int unsigned IW = 5
) (
  input  logic [K-1:0]  mask,
  input  logic [IW-1:0] idx,
  output logic          last
);

  always_comb begin
    last = 1'b1;
    for (int unsigned i = 0; i < K; i++) begin
      if ((i > 32'(idx)) && mask[i]) last = 1'b0;
    end
  end

endmodule

// File: rtl/knns_result_reader.sv
// Captures the packed kNN result vector on start and streams its entries out over valid/ready,
// lowest index first, optionally skipping all-ones (unfilled) slots.
module knns_result_reader
  import knns_pkg::*;
#(
  parameter  int unsigned K          = K_DEF,
  parameter  int unsigned W          = W_DEF,
  parameter  int unsigned SKIP_EMPTY = 1,
  localparam int unsigned IW         = (K > 1) ? $clog2(K) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [K*W-1:0]  min_val_in,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [IW-1:0]   out_idx,
  output logic            out_last,
  output logic            done
);

  localparam logic [W-1:0] SENTINEL = {W{EMPTY_SENTINEL[0]}};

  state_e          state_q, state_d;
  logic [K*W-1:0]  shadow_q, shadow_d;
  logic [K-1:0]    mask_q, mask_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [IW-1:0]   out_idx_q, out_idx_d;
  logic            out_last_q, out_last_d;
  logic            done_q, done_d;
  logic            last_above;

  knns_last_detect #(
    .K  (K),
    .IW (IW)
  ) u_last_detect (
    .mask (mask_q),
    .idx  (idx_q),
    .last (last_above)
  );

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    mask_d      = mask_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = min_val_in;
          for (int unsigned i = 0; i < K; i++) begin
            mask_d[i] = !((SKIP_EMPTY != 0) && (min_val_in[i*W +: W] == SENTINEL));
          end
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = SEEK;
        end
      end
      SEEK: begin
        // Beat outputs are loaded here so they are registered on entry to SEND.
        if (mask_q[idx_q]) begin
          out_valid_d = 1'b1;
          out_data_d  = shadow_q[idx_q*W +: W];
          out_idx_d   = idx_q;
          out_last_d  = last_above;
          state_d     = SEND;
        end else if (idx_q == IW'(K - 1)) begin
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = SEEK;
          end
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      mask_q      <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      mask_q      <= mask_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_knns_result_reader.sv
// Directed bench for knns_result_reader: one instance without and one with empty-slot skipping.
module tb_knns_result_reader;
  import knns_pkg::*;

  localparam int unsigned K  = 20;
  localparam int unsigned W  = 32;
  localparam int unsigned IW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start0 = 1'b0;
  logic            start1 = 1'b0;
  logic            out_ready = 1'b1;
  logic [K*W-1:0]  min_val_in = '0;

  logic            busy0, out_valid0, out_last0, done0;
  logic [W-1:0]    out_data0;
  logic [IW-1:0]   out_idx0;
  logic            busy1, out_valid1, out_last1, done1;
  logic [W-1:0]    out_data1;
  logic [IW-1:0]   out_idx1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  knns_result_reader #(.K(K), .W(W), .SKIP_EMPTY(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .min_val_in(min_val_in),
    .busy(busy0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_idx(out_idx0), .out_last(out_last0), .done(done0)
  );

  knns_result_reader #(.K(K), .W(W), .SKIP_EMPTY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .min_val_in(min_val_in),
    .busy(busy1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_idx(out_idx1), .out_last(out_last1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp(input int base);
    for (int i = 0; i < K; i++) min_val_in[i*W +: W] = 32'(base + i);
  endtask

  task automatic test_reset();
    #12;
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy0); end
    total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid0); end
    total++; if (out_last0 !== 1'b0) begin bad++; $display("FAIL rst_last got=%b exp=0", out_last0); end
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done0); end
    total++; if (out_data0 !== 32'd0) begin bad++; $display("FAIL rst_data got=%0h exp=0", out_data0); end
    total++; if (out_idx0 !== 5'd0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", out_idx0); end
    total++; if ({busy1, out_valid1, done1} !== 3'b000) begin bad++; $display("FAIL rst_dut1 got=%b exp=000", {busy1, out_valid1, done1}); end
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic test_full_stream();
    load_ramp(1);
    out_ready = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    total++; if ({busy0, out_valid0} !== 2'b10) begin bad++; $display("FAIL full_capture got=%b exp=10", {busy0, out_valid0}); end
    for (int k = 0; k < K; k++) begin
      tick();
      total++; if (out_valid0 !== 1'b1) begin bad++; $display("FAIL full_valid k=%0d got=%b exp=1", k, out_valid0); end
      total++; if (out_data0 !== 32'(k + 1)) begin bad++; $display("FAIL full_data k=%0d got=%0d exp=%0d", k, out_data0, k + 1); end
      total++; if (out_idx0 !== 5'(k)) begin bad++; $display("FAIL full_idx k=%0d got=%0d exp=%0d", k, out_idx0, k); end
      total++; if (out_last0 !== (k == K - 1)) begin bad++; $display("FAIL full_last k=%0d got=%b exp=%b", k, out_last0, k == K - 1); end
      tick();
      total++; if ({out_valid0, done0} !== {1'b0, k == K - 1}) begin bad++; $display("FAIL full_after k=%0d got=%b exp=%b", k, {out_valid0, done0}, {1'b0, k == K - 1}); end
    end
    tick();
    total++; if ({busy0, done0} !== 2'b00) begin bad++; $display("FAIL full_end got=%b exp=00", {busy0, done0}); end
  endtask

  task automatic test_backpressure();
    load_ramp(1);
    out_ready = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < K; k++) begin
      tick();
      total++; if ({out_valid0, out_data0, out_idx0} !== {1'b1, 32'(k + 1), 5'(k)}) begin bad++;
        $display("FAIL bp_beat k=%0d got v=%b d=%0d i=%0d exp v=1 d=%0d i=%0d", k, out_valid0, out_data0, out_idx0, k + 1, k); end
      if (k == 5) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          total++; if ({out_valid0, out_data0, out_idx0, out_last0} !== {1'b1, 32'd6, 5'd5, 1'b0}) begin bad++;
            $display("FAIL bp_hold s=%0d got v=%b d=%0d i=%0d l=%b exp v=1 d=6 i=5 l=0", s, out_valid0, out_data0, out_idx0, out_last0); end
        end
        out_ready = 1'b1;
      end
      tick();
      total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL bp_gap k=%0d got=%b exp=0", k, out_valid0); end
    end
    total++; if (done0 !== 1'b1) begin bad++; $display("FAIL bp_done got=%b exp=1", done0); end
    tick();
  endtask

  task automatic test_skip_empty();
    min_val_in = '1;
    min_val_in[0*W +: W] = 32'd3;
    min_val_in[1*W +: W] = 32'd4;
    min_val_in[2*W +: W] = 32'd5;
    out_ready = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if ({out_valid1, out_data1, out_idx1, out_last1} !== {1'b1, 32'(k + 3), 5'(k), k == 2}) begin bad++;
        $display("FAIL skip_beat k=%0d got v=%b d=%0d i=%0d l=%b exp v=1 d=%0d i=%0d l=%b", k, out_valid1, out_data1, out_idx1, out_last1, k + 3, k, k == 2); end
      tick();
      total++; if ({out_valid1, done1} !== {1'b0, k == 2}) begin bad++; $display("FAIL skip_after k=%0d got=%b exp=%b", k, {out_valid1, done1}, {1'b0, k == 2}); end
    end
    tick();
    total++; if ({busy1, done1, out_valid1} !== 3'b000) begin bad++; $display("FAIL skip_end got=%b exp=000", {busy1, done1, out_valid1}); end
  endtask

  task automatic test_all_empty();
    int valid_seen = 0;
    int done_seen  = 0;
    min_val_in = '1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= K + 2; c++) begin
      tick();
      if (out_valid1) valid_seen++;
      if (done1) done_seen++;
      total++; if (done1 !== (c == K)) begin bad++; $display("FAIL empty_done c=%0d got=%b exp=%b", c, done1, c == K); end
    end
    total++; if (valid_seen != 0) begin bad++; $display("FAIL empty_valid got=%0d exp=0", valid_seen); end
    total++; if (done_seen != 1) begin bad++; $display("FAIL empty_done_count got=%0d exp=1", done_seen); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL empty_busy got=%b exp=0", busy1); end
  endtask

  task automatic test_ignored_start();
    load_ramp(1);
    out_ready = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < K; k++) begin
      tick();
      if (k == 1) begin
        min_val_in = {K{32'hA5A5_A5A5}};
        start0 = 1'b1;
      end
      if (k == 2) start0 = 1'b0;
      total++; if ({out_valid0, out_data0, out_idx0} !== {1'b1, 32'(k + 1), 5'(k)}) begin bad++;
        $display("FAIL ign_beat k=%0d got v=%b d=%0h i=%0d exp v=1 d=%0h i=%0d", k, out_valid0, out_data0, out_idx0, k + 1, k); end
      tick();
    end
    total++; if (done0 !== 1'b1) begin bad++; $display("FAIL ign_done got=%b exp=1", done0); end
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL ign_fin_start got=%b exp=0", busy0); end
    tick();
    total++; if ({busy0, out_valid0} !== 2'b00) begin bad++; $display("FAIL ign_fin_idle got=%b exp=00", {busy0, out_valid0}); end
  endtask

  task automatic test_reset_mid();
    bit got_done = 1'b0;
    load_ramp(1);
    out_ready = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      tick();
    end
    tick();
    total++; if ({out_valid0, out_idx0} !== {1'b1, 5'd7}) begin bad++; $display("FAIL mid_pre got v=%b i=%0d exp v=1 i=7", out_valid0, out_idx0); end
    #2 rst = 1'b0;
    #1;
    total++; if ({out_valid0, busy0, done0} !== 3'b000) begin bad++; $display("FAIL mid_async got=%b exp=000", {out_valid0, busy0, done0}); end
    tick();
    rst = 1'b1;
    tick();
    total++; if ({done0, busy0} !== 2'b00) begin bad++; $display("FAIL mid_nodone got=%b exp=00", {done0, busy0}); end
    load_ramp(100);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    total++; if ({out_valid0, out_idx0, out_data0} !== {1'b1, 5'd0, 32'd100}) begin bad++;
      $display("FAIL mid_restart got v=%b i=%0d d=%0d exp v=1 i=0 d=100", out_valid0, out_idx0, out_data0); end
    for (int c = 0; c < 100 && !got_done; c++) begin
      tick();
      if (done0) got_done = 1'b1;
    end
    total++; if (got_done !== 1'b1) begin bad++; $display("FAIL mid_drain got=%b exp=1", got_done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_backpressure();
    test_skip_empty();
    test_all_empty();
    test_ignored_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
